// File: rtl/arbitro_banco_registradores_pkg.sv
`default_nettype none
// +--------------------------------------------------------------------+
// | arbitro_banco_registradores_pkg                                    |
// | Shared types and constants for the register-bank front-end.        |
// | Revision: 1.0                                                      |
// +--------------------------------------------------------------------+
package arbitro_banco_registradores_pkg;
  localparam int DATA_W_DEF = 16;
  localparam int ADDR_W_DEF = 5;

  localparam logic RW_LEITURA = 1'b0;
  localparam logic RW_ESCRITA = 1'b1;

  typedef enum logic [1:0] {
    IDLE       = 2'd0,
    READ_ISSUE = 2'd1,
    READ_WAIT  = 2'd2,
    RESP       = 2'd3
  } estado_t;
endpackage
`default_nettype wire

// File: rtl/arbitro_banco_registradores_fifo_escrita.sv
`default_nettype none
// +--------------------------------------------------------------------+
// | fifo_escrita                                                       |
// | Write buffer of {reg,data} entries with a parallel hazard compare. |
// | Revision: 1.0                                                      |
// +--------------------------------------------------------------------+
module fifo_escrita
  import arbitro_banco_registradores_pkg::*;
#(
  parameter int DATA_W = DATA_W_DEF,
  parameter int ADDR_W = ADDR_W_DEF,
  parameter int DEPTH  = 2
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              push,
  input  logic [ADDR_W-1:0] push_reg,
  input  logic [DATA_W-1:0] push_data,
  input  logic              pop,
  output logic              full,
  output logic              empty,
  output logic [ADDR_W-1:0] head_reg,
  output logic [DATA_W-1:0] head_data,
  input  logic [ADDR_W-1:0] qa,
  input  logic [ADDR_W-1:0] qb,
  output logic              hit
);
  localparam int PW = $clog2(DEPTH);
  localparam logic [PW:0] C_CHEIO = (PW+1)'(DEPTH);

  logic [ADDR_W-1:0] r_reg  [DEPTH];
  logic [DATA_W-1:0] r_data [DEPTH];
  logic [PW-1:0]     r_wr_ptr;
  logic [PW-1:0]     r_rd_ptr;
  logic [PW:0]       r_count;
  logic [DEPTH-1:0]  w_hit_vec;

  assign full      = (r_count == C_CHEIO);
  assign empty     = (r_count == '0);
  assign head_reg  = r_reg[r_rd_ptr];
  assign head_data = r_data[r_rd_ptr];
  assign hit       = |w_hit_vec;

  // A slot is live when its distance from the read pointer is below the count.
  for (genvar i = 0; i < DEPTH; i++) begin : g_slot
    logic [PW-1:0] w_ofs;
    assign w_ofs        = PW'(i) - r_rd_ptr;
    assign w_hit_vec[i] = ({1'b0, w_ofs} < r_count) &&
                          ((r_reg[i] == qa) || (r_reg[i] == qb));
  end

  always_ff @(posedge clk) begin
    if (push) begin
      r_reg[r_wr_ptr]  <= push_reg;
      r_data[r_wr_ptr] <= push_data;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_wr_ptr <= '0;
      r_rd_ptr <= '0;
      r_count  <= '0;
    end else begin
      if (push) r_wr_ptr <= r_wr_ptr + 1'b1;
      if (pop)  r_rd_ptr <= r_rd_ptr + 1'b1;
      unique case ({push, pop})
        2'b10:   r_count <= r_count + 1'b1;
        2'b01:   r_count <= r_count - 1'b1;
        default: ;
      endcase
    end
  end
endmodule
`default_nettype wire

// File: rtl/arbitro_banco_registradores.sv
`default_nettype none
// +--------------------------------------------------------------------+
// | arbitro_banco_registradores                                        |
// | Sequences buffered writes and RAW-ordered reads onto the bank port.|
// | Revision: 1.0                                                      |
// +--------------------------------------------------------------------+
module arbitro_banco_registradores
  import arbitro_banco_registradores_pkg::*;
#(
  parameter int DATA_W   = DATA_W_DEF,
  parameter int ADDR_W   = ADDR_W_DEF,
  parameter int WB_DEPTH = 2
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              rd_valid,
  output logic              rd_ready,
  input  logic [ADDR_W-1:0] rd_a,
  input  logic [ADDR_W-1:0] rd_b,
  output logic              rsp_valid,
  input  logic              rsp_ready,
  output logic [DATA_W-1:0] rsp_a,
  output logic [DATA_W-1:0] rsp_b,
  input  logic              wr_valid,
  output logic              wr_ready,
  input  logic [ADDR_W-1:0] wr_reg,
  input  logic [DATA_W-1:0] wr_data,
  output logic [ADDR_W-1:0] bank_regA,
  output logic [ADDR_W-1:0] bank_regB,
  output logic [ADDR_W-1:0] bank_regC,
  output logic [DATA_W-1:0] bank_dado,
  output logic              bank_RW,
  input  logic [DATA_W-1:0] bank_saidaA,
  input  logic [DATA_W-1:0] bank_saidaB
);
  estado_t           r_estado;
  logic [ADDR_W-1:0] r_idx_a;
  logic [ADDR_W-1:0] r_idx_b;
  logic [DATA_W-1:0] r_rsp_a;
  logic [DATA_W-1:0] r_rsp_b;
  logic              r_rsp_valid;

  logic              w_full;
  logic              w_empty;
  logic              w_hit;
  logic              w_push;
  logic              w_pop;
  logic              w_leitura;
  logic [ADDR_W-1:0] w_head_reg;
  logic [DATA_W-1:0] w_head_data;

  // The port belongs to the read only in a hazard-free READ_ISSUE cycle.
  assign w_leitura = (r_estado == READ_ISSUE) && !w_hit;
  assign w_pop     = !w_empty && !w_leitura;
  assign wr_ready  = !w_full && (r_estado != READ_ISSUE);
  assign w_push    = wr_valid && wr_ready;
  assign rd_ready  = (r_estado == IDLE);

  assign bank_RW   = w_pop ? RW_ESCRITA : RW_LEITURA;
  assign bank_regA = r_idx_a;
  assign bank_regB = r_idx_b;
  assign bank_regC = w_pop ? w_head_reg  : '0;
  assign bank_dado = w_pop ? w_head_data : '0;

  assign rsp_valid = r_rsp_valid;
  assign rsp_a     = r_rsp_a;
  assign rsp_b     = r_rsp_b;

  fifo_escrita #(
    .DATA_W (DATA_W),
    .ADDR_W (ADDR_W),
    .DEPTH  (WB_DEPTH)
  ) u_fifo (
    .clk       (clk),
    .rst_n     (rst_n),
    .push      (w_push),
    .push_reg  (wr_reg),
    .push_data (wr_data),
    .pop       (w_pop),
    .full      (w_full),
    .empty     (w_empty),
    .head_reg  (w_head_reg),
    .head_data (w_head_data),
    .qa        (r_idx_a),
    .qb        (r_idx_b),
    .hit       (w_hit)
  );

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_estado    <= IDLE;
      r_idx_a     <= '0;
      r_idx_b     <= '0;
      r_rsp_a     <= '0;
      r_rsp_b     <= '0;
      r_rsp_valid <= 1'b0;
    end else begin
      unique case (r_estado)
        IDLE: begin
          if (rd_valid) begin
            r_idx_a  <= rd_a;
            r_idx_b  <= rd_b;
            r_estado <= READ_ISSUE;
          end
        end
        READ_ISSUE: begin
          if (!w_hit) r_estado <= READ_WAIT;
        end
        READ_WAIT: begin
          r_rsp_a     <= bank_saidaA;
          r_rsp_b     <= bank_saidaB;
          r_rsp_valid <= 1'b1;
          r_estado    <= RESP;
        end
        RESP: begin
          if (rsp_ready) begin
            r_rsp_valid <= 1'b0;
            r_estado    <= IDLE;
          end
        end
        default: r_estado <= IDLE;
      endcase
    end
  end
endmodule
`default_nettype wire

// File: tb/tb_arbitro_banco_registradores.sv
`default_nettype none
// +--------------------------------------------------------------------+
// | tb_arbitro_banco_registradores                                     |
// | Directed bench with a behavioural 32x16 bank on the port.          |
// | Revision: 1.0                                                      |
// +--------------------------------------------------------------------+
module tb_arbitro_banco_registradores;
  logic        clk = 1'b0;
  logic        rst_n;
  logic        rd_valid, rd_ready, rsp_valid, rsp_ready;
  logic [4:0]  rd_a, rd_b, wr_reg;
  logic [15:0] rsp_a, rsp_b, wr_data;
  logic        wr_valid, wr_ready;
  logic [4:0]  bank_regA, bank_regB, bank_regC;
  logic [15:0] bank_dado;
  logic        bank_RW;
  logic [15:0] bank_saidaA = '0;
  logic [15:0] bank_saidaB = '0;
  logic [15:0] mem [32] = '{default: 16'h0000};

  int checks = 0;
  int errors = 0;

  always #5 clk = ~clk;

  always @(posedge clk) begin
    if (bank_RW) mem[bank_regC] <= bank_dado;
    else begin
      bank_saidaA <= mem[bank_regA];
      bank_saidaB <= mem[bank_regB];
    end
  end

  arbitro_banco_registradores #(.DATA_W(16), .ADDR_W(5), .WB_DEPTH(2)) dut (
    .clk(clk), .rst_n(rst_n),
    .rd_valid(rd_valid), .rd_ready(rd_ready), .rd_a(rd_a), .rd_b(rd_b),
    .rsp_valid(rsp_valid), .rsp_ready(rsp_ready), .rsp_a(rsp_a), .rsp_b(rsp_b),
    .wr_valid(wr_valid), .wr_ready(wr_ready), .wr_reg(wr_reg), .wr_data(wr_data),
    .bank_regA(bank_regA), .bank_regB(bank_regB), .bank_regC(bank_regC),
    .bank_dado(bank_dado), .bank_RW(bank_RW),
    .bank_saidaA(bank_saidaA), .bank_saidaB(bank_saidaB)
  );

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  initial begin
    rst_n = 1'b0; rd_valid = 0; rd_a = 0; rd_b = 0; rsp_ready = 1;
    wr_valid = 0; wr_reg = 0; wr_data = 0;
    #1;
    chk("rst_rsp_valid", rsp_valid, 0);
    chk("rst_rsp_a", rsp_a, 0);
    chk("rst_bank_RW", bank_RW, 0);
    chk("rst_bank_regA", bank_regA, 0);
    chk("rst_rd_ready", rd_ready, 1);
    tick(); tick();
    rst_n = 1'b1;
    tick();

    // read r3,r7 from an all-zero bank
    rd_valid = 1; rd_a = 3; rd_b = 7;
    chk("t1_rd_ready_idle", rd_ready, 1);
    tick(); rd_valid = 0;
    chk("t1_issue_rd_ready", rd_ready, 0);
    chk("t1_issue_RW", bank_RW, 0);
    chk("t1_issue_regA", bank_regA, 3);
    chk("t1_issue_regB", bank_regB, 7);
    chk("t1_issue_rsp_valid", rsp_valid, 0);
    tick();
    chk("t1_wait_rsp_valid", rsp_valid, 0);
    chk("t1_wait_RW", bank_RW, 0);
    tick();
    chk("t1_rsp_valid", rsp_valid, 1);
    chk("t1_rsp_a", rsp_a, 0);
    chk("t1_rsp_b", rsp_b, 0);
    chk("t1_resp_RW", bank_RW, 0);
    tick();
    chk("t1_back_idle", rd_ready, 1);
    chk("t1_rsp_drop", rsp_valid, 0);

    // same-edge write r5 and read r5,r0: one hazard cycle
    wr_valid = 1; wr_reg = 5; wr_data = 16'hBEEF;
    rd_valid = 1; rd_a = 5; rd_b = 0;
    chk("t2_wr_ready", wr_ready, 1);
    tick(); wr_valid = 0; rd_valid = 0;
    chk("t2_haz_RW", bank_RW, 1);
    chk("t2_haz_regC", bank_regC, 5);
    chk("t2_haz_dado", bank_dado, 16'hBEEF);
    chk("t2_haz_wr_ready", wr_ready, 0);
    tick();
    chk("t2_issue_RW", bank_RW, 0);
    chk("t2_issue_regA", bank_regA, 5);
    tick();
    chk("t2_wait_rsp_valid", rsp_valid, 0);
    tick();
    chk("t2_rsp_valid", rsp_valid, 1);
    chk("t2_rsp_a", rsp_a, 16'hBEEF);
    chk("t2_rsp_b", rsp_b, 0);
    tick();

    // three back-to-back writes with no reads
    wr_valid = 1; wr_reg = 1; wr_data = 16'h0001;
    tick();
    chk("t3_w1_RW", bank_RW, 1);
    chk("t3_w1_regC", bank_regC, 1);
    chk("t3_w1_wr_ready", wr_ready, 1);
    wr_reg = 2; wr_data = 16'h0002;
    tick();
    chk("t3_w2_regC", bank_regC, 2);
    chk("t3_w2_dado", bank_dado, 2);
    wr_reg = 3; wr_data = 16'h0003;
    tick(); wr_valid = 0;
    chk("t3_w3_regC", bank_regC, 3);
    chk("t3_w3_dado", bank_dado, 3);
    tick();
    chk("t3_empty_RW", bank_RW, 0);
    chk("t3_mem1", mem[1], 1);
    chk("t3_mem3", mem[3], 3);

    // read r9 while the buffer holds only r4
    wr_valid = 1; wr_reg = 9; wr_data = 16'h0909;
    tick(); wr_valid = 0;
    tick();
    rsp_ready = 0;
    rd_valid = 1; rd_a = 9; rd_b = 1;
    wr_valid = 1; wr_reg = 4; wr_data = 16'h4444;
    tick(); rd_valid = 0; wr_valid = 0;
    chk("t4_issue_RW", bank_RW, 0);
    chk("t4_issue_regA", bank_regA, 9);
    tick();
    chk("t4_wait_RW", bank_RW, 1);
    chk("t4_wait_regC", bank_regC, 4);
    tick();
    chk("t4_rsp_valid", rsp_valid, 1);
    chk("t4_rsp_a", rsp_a, 16'h0909);
    chk("t4_rsp_b", rsp_b, 1);
    chk("t4_mem4", mem[4], 16'h4444);

    // stall RESP for 5 cycles while writing r2
    wr_valid = 1; wr_reg = 2; wr_data = 16'h1234;
    chk("t5_wr_ready", wr_ready, 1);
    for (int i = 0; i < 5; i++) begin
      tick(); wr_valid = 0;
      if (i == 0) chk("t5_wr_regC", bank_regC, 2);
      chk("t5_hold_valid", rsp_valid, 1);
      chk("t5_hold_a", rsp_a, 16'h0909);
      chk("t5_hold_b", rsp_b, 1);
      chk("t5_rd_ready", rd_ready, 0);
    end
    rsp_ready = 1;
    tick();
    chk("t5_mem2", mem[2], 16'h1234);
    rd_valid = 1; rd_a = 2; rd_b = 3;
    tick(); rd_valid = 0;
    tick(); tick();
    chk("t5_rsp_a", rsp_a, 16'h1234);
    chk("t5_rsp_b", rsp_b, 3);
    tick();

    // reset during READ_WAIT with one write buffered
    rd_valid = 1; rd_a = 6; rd_b = 6;
    wr_valid = 1; wr_reg = 12; wr_data = 16'hC0DE;
    tick(); rd_valid = 0; wr_valid = 0;
    chk("t6_issue_RW", bank_RW, 0);
    tick();
    chk("t6_wait_RW", bank_RW, 1);
    rst_n = 0;
    #1;
    chk("t6_rst_RW", bank_RW, 0);
    chk("t6_rst_rsp_valid", rsp_valid, 0);
    chk("t6_rst_rd_ready", rd_ready, 1);
    tick(); tick();
    rst_n = 1;
    tick();
    chk("t6_post_rd_ready", rd_ready, 1);
    chk("t6_post_wr_ready", wr_ready, 1);
    chk("t6_post_RW", bank_RW, 0);
    chk("t6_mem12", mem[12], 0);

    // reset in RESP drops rsp_valid at once
    rsp_ready = 0;
    rd_valid = 1; rd_a = 2; rd_b = 5;
    tick(); rd_valid = 0;
    tick(); tick();
    chk("t7_rsp_valid", rsp_valid, 1);
    chk("t7_rsp_b", rsp_b, 16'hBEEF);
    rst_n = 0;
    #1;
    chk("t7_rst_rsp_valid", rsp_valid, 0);
    chk("t7_rst_rsp_a", rsp_a, 0);
    tick();
    rst_n = 1;
    tick();

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
`default_nettype wire
